coefficient_controller: RTL

Sequencing FSM for the linear-regression coefficient datapath (`CoefficientDP`). It accepts a stream of (x, y) samples from a host over a valid/ready handshake and drives the datapath load, clear and count strobes. After the last sample it sequences the mean, slope (B1) and intercept (B0) register loads, then reports completion. It sits between the sample source and the datapath. It owns no arithmetic; it owns only control and sample counting.

---
 rtl/coefficient_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/coefficient_controller.sv
// Control FSM for the linear-regression datapath: counts samples, strobes accumulators, then sequences mean/B1/B0 loads.
// Latency: done at L+3*(SETTLE+1)+1 after the last accept; backpressure: in_ready only in ACCUM, one accept per cycle.
module coefficient_controller #(
   parameter int MAX_SAMPLES = 255,
   parameter int SETTLE      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       ld0xy,
   output logic       ld0x2,
   output logic       ld0x,
   output logic       ld0y,
   output logic       ldxy,
   output logic       ldx2,
   output logic       ldx,
   output logic       ldy,
   output logic       ld1cnt,
   output logic       inccnt,
   output logic       ldxbar,
   output logic       ldybar,
   output logic       ldB1,
   output logic       ldB0,
   output logic       busy,
   output logic       done,
   output logic       truncated,
   output logic [7:0] sample_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      MEAN,
      SLOPE,
      INTERCEPT,
      DONE
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(MAX_SAMPLES - 1);
   localparam logic [3:0] SETTLE_W = 4'(SETTLE);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] wait_cnt;
   logic       accept;
   logic       settled;
   logic       at_limit;

   assign accept   = in_ready & in_valid;
   assign settled  = (wait_cnt == SETTLE_W);
   assign at_limit = (sample_cnt == LAST_IDX);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      ld0xy     = 1'b0;
      ld0x2     = 1'b0;
      ld0x      = 1'b0;
      ld0y      = 1'b0;
      ldxy      = 1'b0;
      ldx2      = 1'b0;
      ldx       = 1'b0;
      ldy       = 1'b0;
      ld1cnt    = 1'b0;
      inccnt    = 1'b0;
      ldxbar    = 1'b0;
      ldybar    = 1'b0;
      ldB1      = 1'b0;
      ldB0      = 1'b0;
      busy      = (state != IDLE);
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = CLEAR;
         end
         CLEAR: begin
            ld0xy     = 1'b1;
            ld0x2     = 1'b1;
            ld0x      = 1'b1;
            ld0y      = 1'b1;
            ld1cnt    = 1'b1;
            state_nxt = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            ldxy     = in_valid;
            ldx2     = in_valid;
            ldx      = in_valid;
            ldy      = in_valid;
            // n was preset to 1 by CLEAR, so the first sample must not bump it
            inccnt   = in_valid & (sample_cnt != 8'd0);
            if (in_valid && (in_last || at_limit)) state_nxt = MEAN;
         end
         MEAN: begin
            if (settled) begin
               ldxbar    = 1'b1;
               ldybar    = 1'b1;
               state_nxt = SLOPE;
            end
         end
         SLOPE: begin
            if (settled) begin
               ldB1      = 1'b1;
               state_nxt = INTERCEPT;
            end
         end
         INTERCEPT: begin
            if (settled) begin
               ldB0      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         sample_cnt <= 8'd0;
         truncated  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            wait_cnt <= 4'd0;
         else if (state == MEAN || state == SLOPE || state == INTERCEPT)
            wait_cnt <= wait_cnt + 4'd1;

         if (state == IDLE && start)
            sample_cnt <= 8'd0;
         else if (accept)
            sample_cnt <= sample_cnt + 8'd1;

         if (state == IDLE && start)
            truncated <= 1'b0;
         else if (accept && at_limit && !in_last)
            truncated <= 1'b1;
      end
   end

endmodule
